// File: rtl/sdram_arb_pkg.sv
// Shared types and helpers for the N-client SDRAM bridge arbiter.
package sdram_arb_pkg;

  typedef enum logic [1:0] {INIT, IDLE, ISSUE, DONE} arb_state_t;

  localparam int DEF_ADDR_W  = 22;
  localparam int DEF_DATA_W  = 128;
  localparam int MAX_CLIENTS = 8;
  localparam int IDX_W       = 3;
  localparam int NUM_W       = IDX_W + 1;

  typedef struct packed {
    logic             valid;
    logic [IDX_W-1:0] idx;
  } pick_t;

  // First requesting index at or above ptr, wrapping modulo num.
  // With ptr = 0 this degenerates to lowest-index-wins.
  function automatic pick_t rr_pick(input logic [MAX_CLIENTS-1:0] req,
                                    input logic [IDX_W-1:0]       ptr,
                                    input logic [NUM_W-1:0]       num);
    pick_t            p;
    logic [NUM_W-1:0] pos;
    p = '0;
    for (int k = 0; k < MAX_CLIENTS; k++) begin
      pos = {1'b0, ptr} + NUM_W'(k);
      if (pos >= num) pos = pos - num;
      if ((NUM_W'(k) < num) && !p.valid && req[pos[IDX_W-1:0]]) begin
        p.valid = 1'b1;
        p.idx   = pos[IDX_W-1:0];
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/sdram_arbiter_n_picker.sv
// Combinational grant selection: round-robin from ptr, or fixed priority (index 0 highest).
module rr_priority_picker
  import sdram_arb_pkg::*;
#(
  parameter int NUM_CLIENTS = 4,
  parameter int RR_MODE     = 1
) (
  input  logic [NUM_CLIENTS-1:0] req,
  input  logic [IDX_W-1:0]       ptr,
  output logic [IDX_W-1:0]       grant_idx,
  output logic                   grant_valid
);

  pick_t pick;

  // Fixed priority is round-robin with the pointer pinned at zero.
  always_comb begin
    pick        = rr_pick(MAX_CLIENTS'(req), (RR_MODE != 0) ? ptr : '0, NUM_W'(NUM_CLIENTS));
    grant_idx   = pick.idx;
    grant_valid = pick.valid;
  end

endmodule

// File: rtl/sdram_arbiter_n.sv
// N-client arbiter in front of the 128-bit SDRAM bridge. The init writer owns the
// bridge until init_done; afterwards clients are served one transaction at a time.
module sdram_arbiter_n
  import sdram_arb_pkg::*;
#(
  parameter int                NUM_CLIENTS = 4,
  parameter int                ADDR_W      = DEF_ADDR_W,
  parameter int                DATA_W      = DEF_DATA_W,
  parameter int                RR_MODE     = 1,
  parameter logic [ADDR_W-1:0] ADDR_OFFSET = ADDR_W'('hE0000),
  parameter int unsigned       TIMEOUT     = 4095
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            init_we,
  input  logic [ADDR_W-1:0]               init_addr,
  input  logic [DATA_W-1:0]               init_wrdata,
  input  logic                            init_done,
  output logic                            init_ac,
  input  logic [NUM_CLIENTS-1:0]          cl_rd,
  input  logic [NUM_CLIENTS-1:0]          cl_wr,
  input  logic [NUM_CLIENTS*ADDR_W-1:0]   cl_addr,
  input  logic [NUM_CLIENTS*DATA_W/8-1:0] cl_be,
  input  logic [NUM_CLIENTS*DATA_W-1:0]   cl_wrdata,
  output logic [NUM_CLIENTS-1:0]          cl_ac,
  output logic [NUM_CLIENTS-1:0]          cl_wait,
  output logic [DATA_W-1:0]               cl_rddata,
  output logic [ADDR_W+3:0]               bridge_address,
  output logic [DATA_W/8-1:0]             bridge_byte_enable,
  output logic                            bridge_read,
  output logic                            bridge_write,
  output logic [DATA_W-1:0]               bridge_write_data,
  input  logic                            bridge_acknowledge,
  input  logic [DATA_W-1:0]               bridge_read_data,
  output logic                            timeout_err
);

  localparam int BE_W = DATA_W / 8;
  localparam int WD_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [WD_W-1:0] WD_LIMIT = (TIMEOUT == 0) ? '0 : WD_W'(TIMEOUT - 1);

  arb_state_t             state_q, state_d;
  logic [IDX_W-1:0]       ptr_q, ptr_d, gnt_q, gnt_d;
  logic                   bridge_read_q, bridge_read_d, bridge_write_q, bridge_write_d;
  logic [ADDR_W+3:0]      bridge_address_q, bridge_address_d;
  logic [BE_W-1:0]        bridge_byte_enable_q, bridge_byte_enable_d;
  logic [DATA_W-1:0]      bridge_write_data_q, bridge_write_data_d;
  logic [DATA_W-1:0]      cl_rddata_q, cl_rddata_d;
  logic [NUM_CLIENTS-1:0] cl_ac_q, cl_ac_d;
  logic                   init_ac_q, init_ac_d, timeout_err_q, timeout_err_d;
  logic [WD_W-1:0]        wd_q, wd_d;

  logic [NUM_CLIENTS-1:0] req, own_mask;
  logic [IDX_W-1:0]       pick_idx;
  logic                   pick_valid;
  logic [ADDR_W-1:0]      sel_addr;
  logic [BE_W-1:0]        sel_be;
  logic [DATA_W-1:0]      sel_wrdata;
  logic                   sel_rd;

  assign req = cl_rd | cl_wr;

  rr_priority_picker #(
    .NUM_CLIENTS(NUM_CLIENTS),
    .RR_MODE    (RR_MODE)
  ) u_picker (
    .req        (req),
    .ptr        (ptr_q),
    .grant_idx  (pick_idx),
    .grant_valid(pick_valid)
  );

  // Route the picked client's address, enables, data and direction to the latch regs.
  always_comb begin
    sel_addr   = '0;
    sel_be     = '0;
    sel_wrdata = '0;
    sel_rd     = 1'b0;
    for (int i = 0; i < NUM_CLIENTS; i++) begin
      if (pick_idx == IDX_W'(i)) begin
        sel_addr   = cl_addr[i*ADDR_W +: ADDR_W];
        sel_be     = cl_be[i*BE_W +: BE_W];
        sel_wrdata = cl_wrdata[i*DATA_W +: DATA_W];
        sel_rd     = cl_rd[i];
      end
    end
  end

  // A client owns the bus from its issue cycle through its completion cycle.
  always_comb begin
    own_mask = '0;
    if (state_q == ISSUE || state_q == DONE) own_mask = NUM_CLIENTS'(1) << gnt_q;
  end

  assign cl_wait = req & ~own_mask;

  // Next-state and registered-output logic; strobes only change on grant, ack or abort.
  always_comb begin
    state_d              = state_q;
    ptr_d                = ptr_q;
    gnt_d                = gnt_q;
    bridge_read_d        = bridge_read_q;
    bridge_write_d       = bridge_write_q;
    bridge_address_d     = bridge_address_q;
    bridge_byte_enable_d = bridge_byte_enable_q;
    bridge_write_data_d  = bridge_write_data_q;
    cl_rddata_d          = cl_rddata_q;
    cl_ac_d              = '0;
    init_ac_d            = 1'b0;
    timeout_err_d        = timeout_err_q;
    wd_d                 = wd_q;
    unique case (state_q)
      INIT: begin
        if (bridge_write_q) begin
          if (bridge_acknowledge) begin
            bridge_write_d = 1'b0;
            init_ac_d      = 1'b1;
          end
        end else if (init_done) begin
          state_d = IDLE;
        end else if (init_we && !init_ac_q) begin
          bridge_address_d     = {init_addr - ADDR_OFFSET, 4'b0000};
          bridge_byte_enable_d = '1;
          bridge_write_data_d  = init_wrdata;
          bridge_write_d       = 1'b1;
        end
      end
      IDLE: begin
        if (pick_valid) begin
          gnt_d                = pick_idx;
          bridge_address_d     = {sel_addr - ADDR_OFFSET, 4'b0000};
          bridge_byte_enable_d = sel_be;
          bridge_write_data_d  = sel_wrdata;
          bridge_read_d        = sel_rd;
          bridge_write_d       = ~sel_rd;
          wd_d                 = '0;
          state_d              = ISSUE;
        end
      end
      ISSUE: begin
        if (bridge_acknowledge) begin
          bridge_read_d  = 1'b0;
          bridge_write_d = 1'b0;
          if (bridge_read_q) cl_rddata_d = bridge_read_data;
          cl_ac_d = NUM_CLIENTS'(1) << gnt_q;
          state_d = DONE;
        end else if (TIMEOUT != 0 && wd_q == WD_LIMIT) begin
          bridge_read_d  = 1'b0;
          bridge_write_d = 1'b0;
          timeout_err_d  = 1'b1;
          cl_rddata_d    = '0;
          cl_ac_d        = NUM_CLIENTS'(1) << gnt_q;
          state_d        = DONE;
        end else if (TIMEOUT != 0) begin
          wd_d = wd_q + 1'b1;
        end
      end
      DONE: begin
        ptr_d   = (gnt_q == IDX_W'(NUM_CLIENTS - 1)) ? '0 : gnt_q + 1'b1;
        state_d = IDLE;
      end
      default: state_d = INIT;
    endcase
  end

  // State and output registers; reset drops any open strobe immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q              <= INIT;
      ptr_q                <= '0;
      gnt_q                <= '0;
      bridge_read_q        <= 1'b0;
      bridge_write_q       <= 1'b0;
      bridge_address_q     <= '0;
      bridge_byte_enable_q <= '0;
      bridge_write_data_q  <= '0;
      cl_rddata_q          <= '0;
      cl_ac_q              <= '0;
      init_ac_q            <= 1'b0;
      timeout_err_q        <= 1'b0;
      wd_q                 <= '0;
    end else begin
      state_q              <= state_d;
      ptr_q                <= ptr_d;
      gnt_q                <= gnt_d;
      bridge_read_q        <= bridge_read_d;
      bridge_write_q       <= bridge_write_d;
      bridge_address_q     <= bridge_address_d;
      bridge_byte_enable_q <= bridge_byte_enable_d;
      bridge_write_data_q  <= bridge_write_data_d;
      cl_rddata_q          <= cl_rddata_d;
      cl_ac_q              <= cl_ac_d;
      init_ac_q            <= init_ac_d;
      timeout_err_q        <= timeout_err_d;
      wd_q                 <= wd_d;
    end
  end

  assign init_ac            = init_ac_q;
  assign cl_ac              = cl_ac_q;
  assign cl_rddata          = cl_rddata_q;
  assign bridge_address     = bridge_address_q;
  assign bridge_byte_enable = bridge_byte_enable_q;
  assign bridge_read        = bridge_read_q;
  assign bridge_write       = bridge_write_q;
  assign bridge_write_data  = bridge_write_data_q;
  assign timeout_err        = timeout_err_q;

endmodule

// File: tb/tb_sdram_arbiter_n.sv
// Directed bench: a round-robin instance (A) and a fixed-priority instance (B) share
// init, address and data inputs; each has its own request vectors and bridge responder.
module tb_sdram_arbiter_n;

   localparam int N  = 4;
   localparam int AW = 22;
   localparam int DW = 128;
   localparam int BW = DW / 8;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   logic          initWe, initDone;
   logic [AW-1:0] initAddr;
   logic [DW-1:0] initData;
   logic [N-1:0]  clRdA, clWrA, clRdB, clWrB;
   logic [N*AW-1:0] clAddr;
   logic [N*BW-1:0] clBe;
   logic [N*DW-1:0] clWrData;
   logic [DW-1:0] readData;
   int            ackLat;

   logic          initAcA, initAcB, rdA, rdB, wrA, wrB, errA, errB;
   logic          ackA = 1'b0, ackB = 1'b0;
   logic [N-1:0]  clAcA, clAcB, clWaitA, clWaitB;
   logic [DW-1:0] clRdDataA, clRdDataB, wdA, wdB;
   logic [AW+3:0] addrA, addrB;
   logic [BW-1:0] beA, beB;
   int            cntA, cntB;

   int vectors = 0;
   int miscompares = 0;

   logic [AW+3:0] expAddr [N] = '{26'h0010000, 26'h0010100, 26'h0010200, 26'h3200100};
   int            rrOrder [5] = '{0, 1, 2, 3, 0};

   sdram_arbiter_n #(.NUM_CLIENTS(N), .RR_MODE(1), .TIMEOUT(16)) dutA (
      .clk(clk), .reset(reset),
      .init_we(initWe), .init_addr(initAddr), .init_wrdata(initData), .init_done(initDone),
      .init_ac(initAcA),
      .cl_rd(clRdA), .cl_wr(clWrA), .cl_addr(clAddr), .cl_be(clBe), .cl_wrdata(clWrData),
      .cl_ac(clAcA), .cl_wait(clWaitA), .cl_rddata(clRdDataA),
      .bridge_address(addrA), .bridge_byte_enable(beA), .bridge_read(rdA), .bridge_write(wrA),
      .bridge_write_data(wdA), .bridge_acknowledge(ackA), .bridge_read_data(readData),
      .timeout_err(errA));

   sdram_arbiter_n #(.NUM_CLIENTS(N), .RR_MODE(0), .TIMEOUT(16)) dutB (
      .clk(clk), .reset(reset),
      .init_we(initWe), .init_addr(initAddr), .init_wrdata(initData), .init_done(initDone),
      .init_ac(initAcB),
      .cl_rd(clRdB), .cl_wr(clWrB), .cl_addr(clAddr), .cl_be(clBe), .cl_wrdata(clWrData),
      .cl_ac(clAcB), .cl_wait(clWaitB), .cl_rddata(clRdDataB),
      .bridge_address(addrB), .bridge_byte_enable(beB), .bridge_read(rdB), .bridge_write(wrB),
      .bridge_write_data(wdB), .bridge_acknowledge(ackB), .bridge_read_data(readData),
      .timeout_err(errB));

   // Bridge responder for A: one-cycle ack once a strobe has been up ackLat edges (0 = never).
   always @(posedge clk) begin
      if (reset || !(rdA || wrA)) begin
         cntA <= 0;
         ackA <= 1'b0;
      end else begin
         cntA <= cntA + 1;
         ackA <= (ackLat != 0) && (cntA + 1 == ackLat);
      end
   end

   // Bridge responder for B, identical behaviour.
   always @(posedge clk) begin
      if (reset || !(rdB || wrB)) begin
         cntB <= 0;
         ackB <= 1'b0;
      end else begin
         cntB <= cntB + 1;
         ackB <= (ackLat != 0) && (cntB + 1 == ackLat);
      end
   end

   task automatic checkOutput(input string tag, input logic [127:0] got, input logic [127:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   task automatic applyStimulus(input logic [N-1:0] rdAIn, input logic [N-1:0] wrAIn,
                                input logic [N-1:0] rdBIn, input logic [N-1:0] wrBIn);
      clRdA = rdAIn;
      clWrA = wrAIn;
      clRdB = rdBIn;
      clWrB = wrBIn;
   endtask

   task automatic waitStrobe(input bit useB, output logic seen);
      seen = 1'b0;
      for (int c = 0; c < 60 && !seen; c++) begin
         @(negedge clk);
         seen = useB ? (rdB | wrB) : (rdA | wrA);
      end
   endtask

   task automatic waitAck(input bit useB, output logic [N-1:0] ac, output logic prevAck);
      logic lastAck;
      ac = '0;
      prevAck = 1'b0;
      lastAck = useB ? ackB : ackA;
      for (int c = 0; c < 60 && ac == '0; c++) begin
         @(negedge clk);
         ac = useB ? clAcB : clAcA;
         prevAck = lastAck;
         lastAck = useB ? ackB : ackA;
      end
   endtask

   initial begin
      #400000;
      $display("[TB] FAIL global_timeout: got stuck, expected completion");
      $fatal(1);
   end

   initial begin
      logic         s, pa;
      logic [N-1:0] ac;
      int           initAcks, hi;

      reset = 1'b1;
      initWe = 1'b0; initDone = 1'b0; initAddr = '0; initData = '0;
      applyStimulus('0, '0, '0, '0);
      ackLat = 5;
      readData = 128'hDEAD_0000_1111_2222_3333_4444_5555_BEEF;
      clAddr   = {22'h000010, 22'h0E1020, 22'h0E1010, 22'h0E1000};
      clBe     = {16'hA5A3, 16'hA5A2, 16'hA5A1, 16'hA5A0};
      clWrData = {{4{32'hC0DE0003}}, {4{32'hC0DE0002}}, {4{32'hC0DE0001}}, {4{32'hC0DE0000}}};

      repeat (3) @(negedge clk);
      checkOutput("rst_write", 128'(wrA), 128'(0));
      checkOutput("rst_read", 128'(rdA), 128'(0));
      checkOutput("rst_init_ac", 128'(initAcA), 128'(0));
      checkOutput("rst_cl_ac", 128'(clAcA), 128'(0));
      checkOutput("rst_err", 128'(errA), 128'(0));
      checkOutput("rst_addr", 128'(addrA), 128'(0));
      reset = 1'b0;

      // Init phase: three writes through the init port.
      initAcks = 0;
      for (int k = 0; k < 3; k++) begin
         initWe   = 1'b1;
         initAddr = 22'h0E0100 + 22'(k);
         initData = {4{32'h11110000 + 32'(k)}};
         @(negedge clk);
         checkOutput("init_write", 128'(wrA), 128'(1));
         checkOutput("init_addr", 128'(addrA), 128'(26'h0001000 + 26'(16 * k)));
         checkOutput("init_be", 128'(beA), 128'(16'hFFFF));
         checkOutput("init_wdata", 128'(wdA), 128'({4{32'h11110000 + 32'(k)}}));
         s = 1'b0;
         for (int c = 0; c < 30 && !s; c++) begin
            @(negedge clk);
            s = initAcA;
         end
         checkOutput("init_ac", 128'(s), 128'(1));
         checkOutput("init_write_drop", 128'(wrA), 128'(0));
         if (s) initAcks++;
         initWe = 1'b0;
         @(negedge clk);
         checkOutput("init_ac_pulse", 128'(initAcA), 128'(0));
      end
      checkOutput("init_count", 128'(initAcks), 128'(3));

      // Clients requesting during INIT only wait.
      applyStimulus(4'b1111, '0, '0, '0);
      @(negedge clk);
      checkOutput("init_wait", 128'(clWaitA), 128'(4'b1111));
      checkOutput("init_no_grant", 128'(rdA), 128'(0));
      initDone = 1'b1;

      // Round robin, all four held.
      for (int t = 0; t < 5; t++) begin
         waitStrobe(1'b0, s);
         checkOutput("rr_strobe", 128'(s & rdA), 128'(1));
         checkOutput("rr_wait", 128'(clWaitA), 128'(4'hF & ~(4'b0001 << rrOrder[t])));
         checkOutput("rr_addr", 128'(addrA), 128'(expAddr[rrOrder[t]]));
         waitAck(1'b0, ac, pa);
         checkOutput("rr_grant", 128'(ac), 128'(4'b0001 << rrOrder[t]));
      end
      applyStimulus('0, '0, '0, '0);
      @(negedge clk);

      // Client 2 read: strobe one cycle after request, data at cl_ac.
      applyStimulus(4'b0100, '0, '0, '0);
      @(negedge clk);
      checkOutput("rd_latency", 128'(rdA), 128'(1));
      checkOutput("rd_no_write", 128'(wrA), 128'(0));
      checkOutput("rd_addr", 128'(addrA), 128'(expAddr[2]));
      checkOutput("rd_wait_owner", 128'(clWaitA), 128'(0));
      waitAck(1'b0, ac, pa);
      checkOutput("rd_ac", 128'(ac), 128'(4'b0100));
      checkOutput("rd_ack_to_ac", 128'(pa), 128'(1));
      checkOutput("rd_data", clRdDataA, 128'hDEAD_0000_1111_2222_3333_4444_5555_BEEF);
      applyStimulus('0, '0, '0, '0);

      // Client 0 asserts rd and wr: read first, write stays pending.
      applyStimulus(4'b0001, 4'b0001, '0, '0);
      waitStrobe(1'b0, s);
      checkOutput("both_read_first", 128'({rdA, wrA}), 128'(2'b10));
      waitAck(1'b0, ac, pa);
      checkOutput("both_ac1", 128'(ac), 128'(4'b0001));
      applyStimulus('0, 4'b0001, '0, '0);
      waitStrobe(1'b0, s);
      checkOutput("both_write_next", 128'({rdA, wrA}), 128'(2'b01));
      checkOutput("both_wdata", wdA, {4{32'hC0DE0000}});
      checkOutput("both_be", 128'(beA), 128'(16'hA5A0));
      waitAck(1'b0, ac, pa);
      checkOutput("both_ac2", 128'(ac), 128'(4'b0001));
      applyStimulus('0, '0, '0, '0);

      // Fixed priority on B: client 1 starves client 3 while it holds.
      applyStimulus('0, '0, 4'b1010, '0);
      for (int t = 0; t < 3; t++) begin
         waitStrobe(1'b1, s);
         checkOutput("fx_wait", 128'(clWaitB), 128'(4'b1000));
         waitAck(1'b1, ac, pa);
         checkOutput("fx_grant", 128'(ac), 128'(4'b0010));
      end
      applyStimulus('0, '0, 4'b1000, '0);
      waitAck(1'b1, ac, pa);
      checkOutput("fx_grant_low", 128'(ac), 128'(4'b1000));
      applyStimulus('0, '0, '0, '0);

      // Watchdog: no ack, strobe held for 16 cycles then abort.
      ackLat = 0;
      applyStimulus('0, 4'b0010, '0, '0);
      waitStrobe(1'b0, s);
      checkOutput("to_err_before", 128'(errA), 128'(0));
      hi = 0;
      ac = '0;
      for (int c = 0; c < 40 && ac == '0; c++) begin
         if (wrA) hi++;
         @(negedge clk);
         ac = clAcA;
      end
      checkOutput("to_strobe_cycles", 128'(hi), 128'(16));
      checkOutput("to_ac", 128'(ac), 128'(4'b0010));
      checkOutput("to_strobe_drop", 128'(wrA), 128'(0));
      checkOutput("to_err", 128'(errA), 128'(1));
      checkOutput("to_rddata_zero", clRdDataA, 128'(0));
      applyStimulus('0, '0, '0, '0);

      // Normal read after abort: error stays sticky.
      ackLat = 5;
      applyStimulus(4'b0001, '0, '0, '0);
      waitAck(1'b0, ac, pa);
      checkOutput("sticky_ac", 128'(ac), 128'(4'b0001));
      checkOutput("sticky_err", 128'(errA), 128'(1));
      checkOutput("sticky_rddata", clRdDataA, 128'hDEAD_0000_1111_2222_3333_4444_5555_BEEF);
      applyStimulus('0, '0, '0, '0);

      // Reset in the middle of an issued write.
      ackLat = 0;
      applyStimulus('0, 4'b1000, '0, '0);
      waitStrobe(1'b0, s);
      checkOutput("mid_strobe", 128'(wrA), 128'(1));
      repeat (2) @(negedge clk);
      reset = 1'b1;
      #1;
      checkOutput("mid_rst_write", 128'(wrA), 128'(0));
      checkOutput("mid_rst_err", 128'(errA), 128'(0));
      checkOutput("mid_rst_ac", 128'(clAcA), 128'(0));
      initDone = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         checkOutput("post_rst_no_ac", 128'({clAcA, wrA}), 128'(0));
         checkOutput("post_rst_wait", 128'(clWaitA), 128'(4'b1000));
      end
      ackLat = 5;
      initDone = 1'b1;
      waitAck(1'b0, ac, pa);
      checkOutput("post_rst_served", 128'(ac), 128'(4'b1000));
      applyStimulus('0, '0, '0, '0);
      @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
